// File: rtl/mcycle_unit_pkg.sv
// -----------------------------------------------------------------------------
// mcycle_unit_pkg
// Encodings shared between the instruction decoder and the multi-cycle
// multiply/divide unit: FSM state values and the MCycleOp operation codes.
// No ports (package).
// -----------------------------------------------------------------------------
package mcycle_unit_pkg;

   typedef enum logic {
      IDLE      = 1'b0,
      COMPUTING = 1'b1
   } mc_state_e;

   // MCycleOp values driven by the decoder alongside M_Start.
   localparam logic MC_MUL = 1'b0;
   localparam logic MC_DIV = 1'b1;

endpackage

// File: rtl/mcycle_datapath.sv
// -----------------------------------------------------------------------------
// mcycle_datapath
// One combinational iteration of the unsigned shift-add multiplier or the
// restoring divider. The working register layout is shared by both:
//   MUL: {upper accumulator, remaining multiplier bits / product low half}
//   DIV: {partial remainder, dividend bits shifting out / quotient bits in}
// Ports:
//   op_i       operation (MC_MUL / MC_DIV)
//   operand_i  multiplicand (MUL) or divisor (DIV)
//   work_i     current working register, 2*WIDTH bits
//   work_o     working register after one iteration
// -----------------------------------------------------------------------------
module mcycle_datapath
   import mcycle_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               op_i,
   input  logic [WIDTH-1:0]   operand_i,
   input  logic [2*WIDTH-1:0] work_i,
   output logic [2*WIDTH-1:0] work_o
);

   logic [WIDTH-1:0] hi;
   logic [WIDTH:0]   sum;    // WIDTH+1 bits so the carry out of the add is kept
   logic [WIDTH:0]   trial;  // bit WIDTH is the sign of the trial subtraction

   assign hi = work_i[2*WIDTH-1:WIDTH];

   // NOTE: every output of a combinational block gets a value on every path
   // (defaults first), otherwise synthesis infers a latch.
   always_comb begin
      sum    = {1'b0, hi};
      trial  = {hi, work_i[WIDTH-1]} - {1'b0, operand_i};
      work_o = {sum, work_i[WIDTH-1:1]};

      if (work_i[0]) begin
         sum = {1'b0, hi} + {1'b0, operand_i};
      end

      if (op_i == MC_DIV) begin
         if (!trial[WIDTH]) begin
            // Divisor fits: keep the difference, quotient bit 1.
            work_o = {trial[WIDTH-1:0], work_i[WIDTH-2:0], 1'b1};
         end else begin
            // Divisor does not fit: plain shift, quotient bit 0.
            work_o = {work_i[2*WIDTH-2:0], 1'b0};
         end
      end else begin
         // Shift right including the carry bit of the addition.
         work_o = {sum, work_i[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/mcycle_unit.sv
// -----------------------------------------------------------------------------
// mcycle_unit
// Multi-cycle unsigned multiply / divide unit. A launch takes WIDTH iterations;
// Busy stalls the pipeline from the Start cycle until results are ready.
// Ports:
//   CLK       system clock, rising edge
//   RESET     synchronous active-high reset
//   Start     launch request, honoured only in IDLE
//   MCycleOp  MC_MUL / MC_DIV, sampled with Start
//   Operand1  multiplicand / dividend, sampled with Start
//   Operand2  multiplier / divisor, sampled with Start
//   Result1   product low half / quotient
//   Result2   product high half / remainder
//   Busy      combinational stall request
//   Done      one-cycle pulse in the first cycle the new results are visible
// -----------------------------------------------------------------------------
module mcycle_unit
   import mcycle_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             Start,
   input  logic             MCycleOp,
   input  logic [WIDTH-1:0] Operand1,
   input  logic [WIDTH-1:0] Operand2,
   output logic [WIDTH-1:0] Result1,
   output logic [WIDTH-1:0] Result2,
   output logic             Busy,
   output logic             Done
);

   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   mc_state_e          state_q;
   logic [CW-1:0]      count_q;
   logic [WIDTH-1:0]   result1_q;
   logic [WIDTH-1:0]   result2_q;
   logic               done_q;

   logic               op_q;
   logic [WIDTH-1:0]   operand_q;
   logic [2*WIDTH-1:0] work_q;
   logic [2*WIDTH-1:0] work_d;

   logic               launch;

   assign launch = (state_q == IDLE) && Start;

   // Raised in the Start cycle itself so the issuing stage stalls at once.
   assign Busy    = launch || (state_q == COMPUTING);
   assign Result1 = result1_q;
   assign Result2 = result2_q;
   assign Done    = done_q;

   mcycle_datapath #(
      .WIDTH (WIDTH)
   ) u_datapath (
      .op_i      (op_q),
      .operand_i (operand_q),
      .work_i    (work_q),
      .work_o    (work_d)
   );

   // Control FSM, iteration counter and architecturally visible results.
   // NOTE: sequential state is always written with non-blocking assignments so
   // every register samples values from before the edge.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= IDLE;
         count_q   <= '0;
         result1_q <= '0;
         result2_q <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (Start) begin
                  count_q <= '0;
                  state_q <= COMPUTING;
               end
            end
            COMPUTING: begin
               count_q <= count_q + 1'b1;
               if (count_q == LAST) begin
                  // The final iteration goes straight to the result registers.
                  result1_q <= work_d[WIDTH-1:0];
                  result2_q <= work_d[2*WIDTH-1:WIDTH];
                  done_q    <= 1'b1;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Working registers, kept apart from the results so those hold steady
   // while an operation is in flight.
   // NOTE: these carry no reset; every launch reloads them before use, so a
   // reset would only add logic without changing behaviour.
   always_ff @(posedge CLK) begin
      if (launch) begin
         op_q      <= MCycleOp;
         operand_q <= (MCycleOp == MC_MUL) ? Operand1 : Operand2;
         work_q    <= {{WIDTH{1'b0}}, (MCycleOp == MC_MUL) ? Operand2 : Operand1};
      end else if (state_q == COMPUTING) begin
         work_q <= work_d;
      end
   end

endmodule

// File: tb/tb_mcycle_unit.sv
// -----------------------------------------------------------------------------
// tb_mcycle_unit
// Self-checking bench for mcycle_unit (WIDTH = 32): directed vector table,
// hand-written multi-cycle sequences and random operations compared against
// a plain arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_mcycle_unit;

   localparam int W = 32;

   logic         CLK;
   logic         RESET;
   logic         Start;
   logic         MCycleOp;
   logic [W-1:0] Operand1;
   logic [W-1:0] Operand2;
   logic [W-1:0] Result1;
   logic [W-1:0] Result2;
   logic         Busy;
   logic         Done;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string        name;
      logic         op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] r1;
      logic [W-1:0] r2;
   } vec_t;

   vec_t vecs[$];

   mcycle_unit #(
      .WIDTH (W)
   ) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .Start    (Start),
      .MCycleOp (MCycleOp),
      .Operand1 (Operand1),
      .Operand2 (Operand2),
      .Result1  (Result1),
      .Result2  (Result2),
      .Busy     (Busy),
      .Done     (Done)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: unsigned arithmetic straight from the operation definition.
   function automatic void model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r1, output logic [W-1:0] r2);
      logic [2*W-1:0] p;
      if (op == 1'b0) begin
         p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
         r1 = p[W-1:0];
         r2 = p[2*W-1:W];
      end else if (b == '0) begin
         r1 = '1;
         r2 = a;
      end else begin
         r1 = a / b;
         r2 = a % b;
      end
   endfunction

   task automatic add_vec(input string name, input logic op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] r1, input logic [W-1:0] r2);
      vec_t v;
      v.name = name;
      v.op   = op;
      v.a    = a;
      v.b    = b;
      v.r1   = r1;
      v.r2   = r2;
      vecs.push_back(v);
   endtask

   // Launch one operation from IDLE (called at a negedge) and check latency,
   // Done pulse, results and that results hold while busy. pulse_at >= 0
   // re-asserts Start with junk operands during the computation.
   task automatic run_and_check(input string name, input logic op, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [W-1:0] e1,
                                input logic [W-1:0] e2, input int pulse_at);
      int           cycles;
      bit           done_early;
      bit           res_moved;
      logic [W-1:0] r1_0;
      logic [W-1:0] r2_0;
      Start    = 1'b1;
      MCycleOp = op;
      Operand1 = a;
      Operand2 = b;
      #1;
      r1_0       = Result1;
      r2_0       = Result2;
      cycles     = 0;
      done_early = 1'b0;
      res_moved  = 1'b0;
      while (Busy && cycles < 100) begin
         cycles++;
         if (Done && cycles > 1) done_early = 1'b1;
         if (Result1 !== r1_0 || Result2 !== r2_0) res_moved = 1'b1;
         @(posedge CLK);
         @(negedge CLK);
         Start    = (cycles == pulse_at);
         MCycleOp = 1'($urandom);
         Operand1 = $urandom;
         Operand2 = $urandom;
         #1;
      end
      check({name, " busy_cycles"}, cycles, W + 1);
      check({name, " done_pulse"}, Done, 1'b1);
      check({name, " result1"}, Result1, e1);
      check({name, " result2"}, Result2, e2);
      check({name, " no_early_done"}, done_early, 1'b0);
      check({name, " results_held"}, res_moved, 1'b0);
      Start = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      check({name, " done_single"}, Done, 1'b0);
      check({name, " result1_hold"}, Result1, e1);
   endtask

   initial begin
      logic [W-1:0] ra, rb, e1, e2;
      logic         rop;
      int           n;
      bit           seen;

      add_vec("mul_7x6",      1'b0, 32'd7,          32'd6,          32'd42,         32'd0);
      add_vec("mul_max",      1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  32'hFFFF_FFFE);
      add_vec("div_100_7",    1'b1, 32'd100,        32'd7,          32'd14,         32'd2);
      add_vec("div_msb_3",    1'b1, 32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  32'd2);
      add_vec("div_by_zero",  1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5);
      add_vec("mul_zero",     1'b0, 32'd0,          32'hDEAD_BEEF,  32'd0,          32'd0);
      add_vec("div_zero_num", 1'b1, 32'd0,          32'd9,          32'd0,          32'd0);
      add_vec("div_max_1",    1'b1, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0);
      add_vec("div_max_max",  1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0);
      add_vec("mul_hi_carry", 1'b0, 32'h8000_0001,  32'h0000_0003,  32'h8000_0003,  32'd1);

      RESET    = 1'b1;
      Start    = 1'b0;
      MCycleOp = 1'b0;
      Operand1 = '0;
      Operand2 = '0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RESET = 1'b0;
      #1;
      check("reset busy",    Busy,    1'b0);
      check("reset result1", Result1, '0);
      check("reset result2", Result2, '0);
      check("reset done",    Done,    1'b0);

      foreach (vecs[i]) begin
         run_and_check(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r1, vecs[i].r2, -1);
      end

      // Start pulsed again mid-computation is ignored.
      run_and_check("mul_3x4_restart", 1'b0, 32'd3, 32'd4, 32'd12, 32'd0, 10);

      // Start held through Done launches the next operation back-to-back.
      Start    = 1'b1;
      MCycleOp = 1'b0;
      Operand1 = 32'd3;
      Operand2 = 32'd4;
      repeat (31) begin
         @(posedge CLK);
         @(negedge CLK);
         Start = 1'b0;
      end
      @(posedge CLK);
      @(negedge CLK);
      #1;
      check("b2b last_iter busy", Busy, 1'b1);
      check("b2b last_iter done", Done, 1'b0);
      Start    = 1'b1;
      MCycleOp = 1'b0;
      Operand1 = 32'd5;
      Operand2 = 32'd6;
      @(posedge CLK);
      @(negedge CLK);
      #1;
      check("b2b done",      Done,    1'b1);
      check("b2b busy_held", Busy,    1'b1);
      check("b2b result1",   Result1, 32'd12);
      @(posedge CLK);
      @(negedge CLK);
      Start    = 1'b0;
      Operand1 = $urandom;
      Operand2 = $urandom;
      #1;
      n = 0;
      while (Busy && n < 100) begin
         n++;
         @(posedge CLK);
         @(negedge CLK);
         #1;
      end
      check("b2b second busy_cycles", n, W);
      check("b2b second done",    Done,    1'b1);
      check("b2b second result1", Result1, 32'd30);
      check("b2b second result2", Result2, 32'd0);
      @(posedge CLK);
      @(negedge CLK);

      // Reset in the middle of a divide aborts it and clears the results.
      Start    = 1'b1;
      MCycleOp = 1'b1;
      Operand1 = 32'd1000;
      Operand2 = 32'd7;
      repeat (14) begin
         @(posedge CLK);
         @(negedge CLK);
         Start = 1'b0;
      end
      RESET = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      RESET = 1'b0;
      #1;
      check("abort busy",    Busy,    1'b0);
      check("abort result1", Result1, '0);
      check("abort result2", Result2, '0);
      check("abort done",    Done,    1'b0);
      seen = 1'b0;
      repeat (40) begin
         @(posedge CLK);
         @(negedge CLK);
         if (Done || Busy) seen = 1'b1;
      end
      check("abort stays_quiet", seen, 1'b0);
      run_and_check("mul_2x3_after_abort", 1'b0, 32'd2, 32'd3, 32'd6, 32'd0, -1);

      // Random operations against the reference model.
      for (int k = 0; k < 24; k++) begin
         rop = 1'($urandom_range(0, 1));
         ra  = $urandom;
         rb  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : $urandom;
         if ($urandom_range(0, 5) == 0) ra = W'($urandom_range(0, 15));
         model(rop, ra, rb, e1, e2);
         run_and_check($sformatf("rand%0d_%s", k, rop ? "div" : "mul"), rop, ra, rb, e1, e2, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
